// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU constants and fetch state encoding
package cpu_defs_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 8;

    // Encoding that stops the CPU; InstMem word 0 holds it so a stray jump to 0 halts.
    localparam logic [INST_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - control/InstMem side bus of the fetch unit
interface inst_fetch_unit_if #(
    parameter int unsigned ADDR_W = cpu_defs_pkg::PC_W
) ();
    import cpu_defs_pkg::*;

    logic                fetch_req;
    logic                pc_load;
    logic [ADDR_W-1:0]   pc_load_val;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INST_W-1:0]   imem_data;
    logic [INST_W-1:0]   ir;
    logic                ir_valid;
    logic [ADDR_W-1:0]   pc;
    logic                halted;
    logic                addr_err;
    logic [15:0]         inst_count;

    // Control FSM and InstMem side
    modport master (
        output fetch_req, pc_load, pc_load_val, imem_data,
        input  imem_addr, ir, ir_valid, pc, halted, addr_err, inst_count
    );

    // Fetch unit side
    modport slave (
        input  fetch_req, pc_load, pc_load_val, imem_data,
        output imem_addr, ir, ir_valid, pc, halted, addr_err, inst_count
    );

endinterface

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with load/increment mux and fetch-address bypass
module pc_register #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    input  logic              i_load_en,
    output logic [ADDR_W-1:0] o_fa,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // A taken branch/jump redirects the very fetch issued in the same cycle.
    assign o_fa = i_load ? i_load_val : r_pc;
    assign o_pc = r_pc;

    // Fetch advances past the effective address (wraps naturally); bare load just retargets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_inc) begin
            r_pc <= o_fa + ADDR_W'(1);
        end else if (i_load_en) begin
            r_pc <= i_load_val;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch stage: PC, InstMem addressing, IR latch, halt detection
module inst_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter int unsigned       ADDR_W    = PC_W,
    parameter int unsigned       MEM_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(1),
    parameter logic [INST_W-1:0] HALT_WORD = cpu_defs_pkg::HALT_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_unit_if.slave   bus
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] w_fa;
    logic [ADDR_W-1:0] w_pc;
    logic [INST_W-1:0] r_ir;
    logic              r_addr_err;
    logic [15:0]       r_inst_count;
    logic              w_active;
    logic              w_in_range;
    logic              w_is_halt;
    logic              w_fetch_ok;
    logic              w_fetch_oor;
    logic              w_pc_load;

    // Once halted nothing but reset may change state, so every update is gated by w_active.
    assign w_active    = (r_state != HALT);
    assign w_in_range  = (32'(w_fa) < MEM_DEPTH);
    assign w_is_halt   = (bus.imem_data == HALT_WORD);
    assign w_fetch_ok  = w_active && bus.fetch_req && w_in_range;
    assign w_fetch_oor = w_active && bus.fetch_req && !w_in_range;
    assign w_pc_load   = w_active && bus.pc_load && !bus.fetch_req;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (bus.pc_load),
        .i_load_val (bus.pc_load_val),
        .i_inc      (w_fetch_ok),
        .i_load_en  (w_pc_load),
        .o_fa       (w_fa),
        .o_pc       (w_pc)
    );

    assign bus.imem_addr  = w_fa;
    assign bus.pc         = w_pc;
    assign bus.ir         = r_ir;
    assign bus.addr_err   = r_addr_err;
    assign bus.inst_count = r_inst_count;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: any fetch leaves IDLE/HOLD; halt word or bad address parks in HALT
    always_comb begin
        w_state_nxt = r_state;
        if (w_fetch_oor || (w_fetch_ok && w_is_halt)) begin
            w_state_nxt = HALT;
        end else if (w_fetch_ok) begin
            w_state_nxt = HOLD;
        end
    end

    // Outputs decoded from state: HOLD means IR is a live instruction, HALT is sticky
    always_comb begin
        bus.ir_valid = (r_state == HOLD);
        bus.halted   = (r_state == HALT);
    end

    // IR captures every in-range fetch, the halt word included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if (w_fetch_ok) begin
            r_ir <= bus.imem_data;
        end
    end

    // Sticky flag for a fetch past the populated InstMem
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else if (w_fetch_oor) begin
            r_addr_err <= 1'b1;
        end
    end

    // Saturating count of useful (non-halt) fetches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_count <= '0;
        end else if (w_fetch_ok && !w_is_halt && (r_inst_count != 16'hFFFF)) begin
            r_inst_count <= r_inst_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    logic [31:0] mem [0:63];

    inst_fetch_unit_if #(.ADDR_W(8)) bus_a ();
    inst_fetch_unit_if #(.ADDR_W(8)) bus_b ();

    inst_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    inst_fetch_unit #(
        .MEM_DEPTH (256),
        .RESET_PC  (8'hFF)
    ) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_a.imem_data = (bus_a.imem_addr < 8'd64) ? mem[bus_a.imem_addr[5:0]] : 32'hDEAD_BEEF;
    assign bus_b.imem_data = {24'h5A5A5A, bus_b.imem_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic pl, input logic [7:0] pv);
        @(negedge clk);
        bus_a.fetch_req   = fr;
        bus_a.pc_load     = pl;
        bus_a.pc_load_val = pv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i);
        mem[0]  = 32'hFFFF_FFFF;
        mem[1]  = 32'h2001_0009;
        mem[4]  = 32'h8C86_0000;
        mem[8]  = 32'h1520_000B;
        mem[11] = 32'h2084_0001;

        rst_n = 1'b0;
        bus_a.fetch_req = 1'b0; bus_a.pc_load = 1'b0; bus_a.pc_load_val = 8'd0;
        bus_b.fetch_req = 1'b0; bus_b.pc_load = 1'b0; bus_b.pc_load_val = 8'd0;
        repeat (2) tick();
        chk("rst_pc",       32'(bus_a.pc), 32'd1);
        chk("rst_ir",       bus_a.ir, 32'd0);
        chk("rst_ir_valid", 32'(bus_a.ir_valid), 32'd0);
        chk("rst_halted",   32'(bus_a.halted), 32'd0);
        chk("rst_addr_err", 32'(bus_a.addr_err), 32'd0);
        chk("rst_count",    32'(bus_a.inst_count), 32'd0);
        chk("rst_wrap_pc",  32'(bus_b.pc), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 8'd0);
        chk("t1_imem_addr", 32'(bus_a.imem_addr), 32'd1);
        tick();
        chk("t1_ir",       bus_a.ir, 32'h2001_0009);
        chk("t1_ir_valid", 32'(bus_a.ir_valid), 32'd1);
        chk("t1_pc",       32'(bus_a.pc), 32'd2);
        chk("t1_count",    32'(bus_a.inst_count), 32'd1);

        repeat (7) tick();
        chk("t2_ir",    bus_a.ir, 32'h1520_000B);
        chk("t2_pc",    32'(bus_a.pc), 32'd9);
        chk("t2_count", 32'(bus_a.inst_count), 32'd8);

        drive(1'b0, 1'b0, 8'd0);
        tick();
        chk("idle_ir",    bus_a.ir, 32'h1520_000B);
        chk("idle_pc",    32'(bus_a.pc), 32'd9);
        chk("idle_valid", 32'(bus_a.ir_valid), 32'd1);

        drive(1'b0, 1'b1, 8'd11);
        chk("t3_load_addr", 32'(bus_a.imem_addr), 32'd11);
        tick();
        chk("t3_load_pc",    32'(bus_a.pc), 32'd11);
        chk("t3_load_ir",    bus_a.ir, 32'h1520_000B);
        chk("t3_load_count", 32'(bus_a.inst_count), 32'd8);
        drive(1'b1, 1'b0, 8'd0);
        tick();
        chk("t3_br_ir",    bus_a.ir, 32'h2084_0001);
        chk("t3_br_pc",    32'(bus_a.pc), 32'd12);
        chk("t3_br_count", 32'(bus_a.inst_count), 32'd9);
        drive(1'b1, 1'b1, 8'd4);
        chk("t3_jf_addr", 32'(bus_a.imem_addr), 32'd4);
        tick();
        chk("t3_jf_ir",    bus_a.ir, 32'h8C86_0000);
        chk("t3_jf_pc",    32'(bus_a.pc), 32'd5);
        chk("t3_jf_count", 32'(bus_a.inst_count), 32'd10);

        drive(1'b1, 1'b1, 8'd0);
        tick();
        chk("t4_halted",   32'(bus_a.halted), 32'd1);
        chk("t4_ir",       bus_a.ir, 32'hFFFF_FFFF);
        chk("t4_ir_valid", 32'(bus_a.ir_valid), 32'd0);
        chk("t4_count",    32'(bus_a.inst_count), 32'd10);
        chk("t4_pc",       32'(bus_a.pc), 32'd1);
        chk("t4_addr_err", 32'(bus_a.addr_err), 32'd0);
        drive(1'b1, 1'b1, 8'd7);
        chk("t4_frz_addr", 32'(bus_a.imem_addr), 32'd7);
        tick();
        tick();
        chk("t4_frz_pc",     32'(bus_a.pc), 32'd1);
        chk("t4_frz_ir",     bus_a.ir, 32'hFFFF_FFFF);
        chk("t4_frz_halted", 32'(bus_a.halted), 32'd1);
        chk("t4_frz_count",  32'(bus_a.inst_count), 32'd10);

        drive(1'b0, 1'b0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_pc",     32'(bus_a.pc), 32'd1);
        chk("t6_async_ir",     bus_a.ir, 32'd0);
        chk("t6_async_halted", 32'(bus_a.halted), 32'd0);
        chk("t6_async_count",  32'(bus_a.inst_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'd0);
        tick();
        chk("t6_refetch_ir", bus_a.ir, 32'h2001_0009);
        chk("t6_refetch_pc", 32'(bus_a.pc), 32'd2);

        drive(1'b1, 1'b1, 8'd63);
        tick();
        chk("edge63_ir",       bus_a.ir, 32'h2000_003F);
        chk("edge63_pc",       32'(bus_a.pc), 32'd64);
        chk("edge63_count",    32'(bus_a.inst_count), 32'd2);
        chk("edge63_addr_err", 32'(bus_a.addr_err), 32'd0);

        drive(1'b1, 1'b1, 8'd64);
        tick();
        chk("t5_oor_addr_err", 32'(bus_a.addr_err), 32'd1);
        chk("t5_oor_halted",   32'(bus_a.halted), 32'd1);
        chk("t5_oor_ir",       bus_a.ir, 32'h2000_003F);
        chk("t5_oor_ir_valid", 32'(bus_a.ir_valid), 32'd0);
        chk("t5_oor_pc",       32'(bus_a.pc), 32'd64);
        chk("t5_oor_count",    32'(bus_a.inst_count), 32'd2);

        drive(1'b1, 1'b0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_mid_addr_err", 32'(bus_a.addr_err), 32'd0);
        chk("t6_mid_halted",   32'(bus_a.halted), 32'd0);
        tick();
        chk("t6_mid_pc", 32'(bus_a.pc), 32'd1);
        chk("t6_mid_ir", bus_a.ir, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_after_ir",    bus_a.ir, 32'h2001_0009);
        chk("t6_after_count", 32'(bus_a.inst_count), 32'd1);

        drive(1'b0, 1'b1, 8'hFF);
        tick();
        chk("t5_ff_pc", 32'(bus_a.pc), 32'hFF);
        drive(1'b1, 1'b0, 8'd0);
        chk("t5_ff_addr", 32'(bus_a.imem_addr), 32'hFF);
        tick();
        chk("t5_ff_addr_err", 32'(bus_a.addr_err), 32'd1);
        chk("t5_ff_halted",   32'(bus_a.halted), 32'd1);
        chk("t5_ff_pc_held",  32'(bus_a.pc), 32'hFF);
        chk("t5_ff_ir",       bus_a.ir, 32'h2001_0009);

        @(negedge clk);
        bus_b.fetch_req = 1'b1;
        #1;
        chk("wrap_addr", 32'(bus_b.imem_addr), 32'hFF);
        tick();
        chk("wrap_pc",    32'(bus_b.pc), 32'd0);
        chk("wrap_ir",    bus_b.ir, 32'h5A5A_5AFF);
        chk("wrap_count", 32'(bus_b.inst_count), 32'd1);
        repeat (65533) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(bus_b.inst_count), 32'h0000_FFFE);
        tick();
        chk("sat_ffff", 32'(bus_b.inst_count), 32'h0000_FFFF);
        tick();
        chk("sat_hold",  32'(bus_b.inst_count), 32'h0000_FFFF);
        chk("sat_valid", 32'(bus_b.ir_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
